// File: rtl/image_scalar.sv
// 3x3 neighbour-averaging core: sums the 8 neighbours of a target pixel
// through a 3-stage adder tree and emits a rounded (or truncated) mean.
module image_scalar #(
  parameter int DW    = 8,
  parameter bit ROUND = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] T1,
  input  logic [DW-1:0] T2,
  input  logic [DW-1:0] T3,
  input  logic [DW-1:0] T4,
  input  logic [DW-1:0] B1,
  input  logic [DW-1:0] B2,
  input  logic [DW-1:0] B3,
  input  logic [DW-1:0] B4,
  output logic [DW-1:0] Tpix
);

  localparam logic [DW+2:0] RND = ROUND ? (DW+3)'(4) : '0;

  logic [7:0][DW-1:0] pix;
  logic [3:0][DW:0]   s1;
  logic [1:0][DW+1:0] s2;
  logic [DW+2:0]      s3;

  assign pix = {B4, B3, B2, B1, T4, T3, T2, T1};

  // Stage 1: pairwise sums (T1+T2, T3+T4, B1+B2, B3+B4)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        s1[i] <= {1'b0, pix[2*i]} + {1'b0, pix[2*i+1]};
    end
  end

  // Stage 2: top-half and bottom-half sums
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2 <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        s2[i] <= {1'b0, s1[2*i]} + {1'b0, s1[2*i+1]};
    end
  end

  // Max 8*(2^DW-1)+4 still fits DW+3 bits, so the shifted result fits DW bits
  assign s3 = {1'b0, s2[0]} + {1'b0, s2[1]} + RND;

  // Stage 3: divide by 8
  always_ff @(posedge clk or posedge rst) begin
    if (rst) Tpix <= '0;
    else     Tpix <= DW'(s3 >> 3);
  end

endmodule

// File: tb/tb_image_scalar.sv
// Directed bench for image_scalar: table of window vectors plus hand-written
// latency, streaming and reset sequences on rounding and truncating instances.
module tb_image_scalar;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] T1, T2, T3, T4, B1, B2, B3, B4;
  logic [7:0] tpix_r, tpix_t;

  int checks = 0;
  int errors = 0;

  image_scalar #(.DW(8), .ROUND(1'b1)) dut (
    .clk(clk), .rst(rst),
    .T1(T1), .T2(T2), .T3(T3), .T4(T4),
    .B1(B1), .B2(B2), .B3(B3), .B4(B4),
    .Tpix(tpix_r)
  );

  image_scalar #(.DW(8), .ROUND(1'b0)) dut_t (
    .clk(clk), .rst(rst),
    .T1(T1), .T2(T2), .T3(T3), .T4(T4),
    .B1(B1), .B2(B2), .B3(B3), .B4(B4),
    .Tpix(tpix_t)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [7:0][7:0] px;   // {B4,B3,B2,B1,T4,T3,T2,T1}
    logic [7:0]     er;    // expected with rounding
    logic [7:0]     et;    // expected truncating
  } vec_t;

  vec_t vecs[10];
  logic [7:0] hist[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0][7:0] v);
    {B4, B3, B2, B1, T4, T3, T2, T1} = v;
  endtask

  task automatic drive_all(input logic [7:0] v);
    drive({8{v}});
  endtask

  initial begin
    vecs[0] = '{"uni80",   {8{8'h80}},                                       8'h80, 8'h80};
    vecs[1] = '{"uniFF",   {8{8'hFF}},                                       8'hFF, 8'hFF};
    vecs[2] = '{"uni00",   {8{8'h00}},                                       8'h00, 8'h00};
    vecs[3] = '{"mixed",   {{4{8'h20}}, {4{8'h10}}},                         8'h18, 8'h18};
    vecs[4] = '{"t1_4",    {56'h0, 8'h04},                                   8'h01, 8'h00};
    vecs[5] = '{"t1_3",    {56'h0, 8'h03},                                   8'h00, 8'h00};
    vecs[6] = '{"s2037",   {8'hFC, {7{8'hFF}}},                              8'hFF, 8'hFE};
    vecs[7] = '{"ramp1_8", {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'h05, 8'h04};
    vecs[8] = '{"uni55",   {8{8'h55}},                                       8'h55, 8'h55};
    vecs[9] = '{"b4_only", {8'h0C, 56'h0},                                   8'h02, 8'h01};

    // Reset state, then load a nonzero result
    drive_all(8'h00);
    #2;
    chk("reset_r", tpix_r, 8'h00);
    chk("reset_t", tpix_t, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    drive_all(8'hFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("preload", tpix_r, 8'hFF);

    // Asynchronous reset mid-cycle with inputs at 0xFF
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_r", tpix_r, 8'h00);
    chk("async_rst_t", tpix_t, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held", tpix_r, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    drive_all(8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("release_zero", tpix_r, 8'h00);

    // Exact latency: visible after third edge, not before
    drive_all(8'h80);
    @(posedge clk); @(negedge clk);
    chk("lat_e1", tpix_r, 8'h00);
    @(posedge clk); @(negedge clk);
    chk("lat_e2", tpix_r, 8'h00);
    @(posedge clk); @(negedge clk);
    chk("lat_e3", tpix_r, 8'h80);
    @(posedge clk); @(negedge clk);
    chk("lat_hold", tpix_r, 8'h80);

    // Table-driven vectors, each held three edges
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].px);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk({vecs[i].name, "_r"}, tpix_r, vecs[i].er);
      chk({vecs[i].name, "_t"}, tpix_t, vecs[i].et);
    end

    // Streaming with a one-cycle reset pulse partway through
    drive_all(8'h00);
    repeat (3) @(posedge clk);
    hist = '{8'h00, 8'h00, 8'h00};
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk($sformatf("stream%0d_r", j), tpix_r, hist[0]);
      chk($sformatf("stream%0d_t", j), tpix_t, hist[0]);
      void'(hist.pop_front());
      if (j == 9) begin
        rst = 1'b1;
        drive_all(8'hAA);
        #1;
        chk("stream_rst_r", tpix_r, 8'h00);
        chk("stream_rst_t", tpix_t, 8'h00);
        hist = '{8'h00, 8'h00, 8'h00};
      end else begin
        rst = 1'b0;
        drive_all(8'(j + 1));
        hist.push_back(8'(j + 1));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
